// File: rtl/sdram_test_pkg.sv
// Shared encodings, FSM states and pattern generator for the SDRAM
// pattern tester and the controller wrapper.
package sdram_test_pkg;

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WRITE_GAP,
      ST_READ,
      ST_READ_GAP,
      ST_DONE
   } state_t;

   function automatic logic [15:0] pattern(
      input logic [15:0] addr,
      input logic        pass,
      input logic [15:0] seed
   );
      return addr ^ seed ^ {16{pass}};
   endfunction

endpackage

// File: rtl/sdram_test_watchdog.sv
// Per-state stall counter; expire stays high once the limit is reached
// until the next clear.
module sdram_test_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   assign expire = (count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (!expire)
         count <= count + CW'(1);
   end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Write / read-back / compare traffic generator driving the SDRAM
// controller request port, with optional complemented second pass.
module sdram_pattern_tester
   import sdram_test_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH     = 22,
   parameter int unsigned           DATA_WIDTH     = 16,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LAST      = 22'h3F_FFFF,
   parameter logic [15:0]           SEED           = 16'h0000,
   parameter bit                    INVERT_PASS    = 1'b1,
   parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic [1:0]            command,
   output logic [ADDR_WIDTH-1:0] data_address,
   output logic [DATA_WIDTH-1:0] data_write,
   input  logic [DATA_WIDTH-1:0] data_read,
   input  logic                  data_read_valid,
   input  logic                  data_write_done,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [15:0]           error_count,
   output logic [ADDR_WIDTH-1:0] first_err_address,
   output logic [DATA_WIDTH-1:0] first_err_read,
   output logic [DATA_WIDTH-1:0] first_err_expected
);

   state_t                state, state_d;
   logic                  pass_sel, pass_sel_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [1:0]            command_d;
   logic [DATA_WIDTH-1:0] data_write_d, expected;
   logic                  busy_d, done_d, pass_d, timeout_d;
   logic [15:0]           err_d;
   logic [ADDR_WIDTH-1:0] fa_d;
   logic [DATA_WIDTH-1:0] fr_d, fe_d;
   logic                  at_last, wd_clear, wd_expire;

   function automatic logic [DATA_WIDTH-1:0] word(
      input logic [ADDR_WIDTH-1:0] a,
      input logic                  p
   );
      return DATA_WIDTH'(pattern(16'(a), p, SEED));
   endfunction

   sdram_test_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (wd_clear),
      .expire (wd_expire)
   );

   always_comb begin
      state_d    = state;
      pass_sel_d = pass_sel;
      addr_d     = data_address;
      timeout_d  = timeout;
      err_d      = error_count;
      fa_d       = first_err_address;
      fr_d       = first_err_read;
      fe_d       = first_err_expected;
      expected   = word(data_address, pass_sel);
      at_last    = (data_address == ADDR_LAST);

      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_WRITE;
               pass_sel_d = 1'b0;
               addr_d     = '0;
               timeout_d  = 1'b0;
               err_d      = '0;
               fa_d       = '0;
               fr_d       = '0;
               fe_d       = '0;
            end
         end
         ST_WRITE: begin
            if (data_write_done) begin
               if (at_last) begin
                  addr_d  = '0;
                  state_d = ST_READ_GAP;
               end else begin
                  addr_d  = data_address + ADDR_WIDTH'(1);
                  state_d = ST_WRITE_GAP;
               end
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_WRITE_GAP: state_d = ST_WRITE;
         ST_READ: begin
            if (data_read_valid) begin
               if (data_read != expected) begin
                  if (error_count != 16'hFFFF)
                     err_d = error_count + 16'd1;
                  if (error_count == 16'd0) begin
                     fa_d = data_address;
                     fr_d = data_read;
                     fe_d = expected;
                  end
               end
               if (at_last && !pass_sel && INVERT_PASS) begin
                  pass_sel_d = 1'b1;
                  addr_d     = '0;
                  state_d    = ST_WRITE_GAP;
               end else if (at_last) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d  = data_address + ADDR_WIDTH'(1);
                  state_d = ST_READ_GAP;
               end
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_READ_GAP: state_d = ST_READ;
         default: state_d = ST_IDLE;
      endcase

      // outputs are registered, so derive them from the next state
      command_d    = CMD_IDLE;
      data_write_d = data_write;
      if (state_d == ST_WRITE) begin
         command_d    = CMD_WRITE;
         data_write_d = word(addr_d, pass_sel_d);
      end else if (state_d == ST_READ) begin
         command_d = CMD_READ;
      end
      busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d   = (state_d == ST_DONE);
      pass_d   = done_d && (err_d == 16'd0) && !timeout_d;
      wd_clear = (state_d != state);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= ST_IDLE;
         pass_sel           <= 1'b0;
         command            <= CMD_IDLE;
         data_address       <= '0;
         data_write         <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         pass               <= 1'b0;
         timeout            <= 1'b0;
         error_count        <= '0;
         first_err_address  <= '0;
         first_err_read     <= '0;
         first_err_expected <= '0;
      end else begin
         state              <= state_d;
         pass_sel           <= pass_sel_d;
         command            <= command_d;
         data_address       <= addr_d;
         data_write         <= data_write_d;
         busy               <= busy_d;
         done               <= done_d;
         pass               <= pass_d;
         timeout            <= timeout_d;
         error_count        <= err_d;
         first_err_address  <= fa_d;
         first_err_read     <= fr_d;
         first_err_expected <= fe_d;
      end
   end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench: 3-cycle behavioural controller with fault modes,
// hand-computed expectations for a 16-word range.
module tb_sdram_pattern_tester;
   import sdram_test_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  command;
   logic [21:0] data_address;
   logic [15:0] data_write;
   logic [15:0] data_read = '0;
   logic        data_read_valid = 1'b0;
   logic        data_write_done = 1'b0;
   logic        busy, done, pass, timeout;
   logic [15:0] error_count;
   logic [21:0] first_err_address;
   logic [15:0] first_err_read, first_err_expected;

   always #5 clk = ~clk;

   sdram_pattern_tester #(
      .ADDR_WIDTH    (22),
      .DATA_WIDTH    (16),
      .ADDR_LAST     (22'd15),
      .SEED          (16'h0000),
      .INVERT_PASS   (1'b1),
      .TIMEOUT_CYCLES(1024)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .command           (command),
      .data_address      (data_address),
      .data_write        (data_write),
      .data_read         (data_read),
      .data_read_valid   (data_read_valid),
      .data_write_done   (data_write_done),
      .busy              (busy),
      .done              (done),
      .pass              (pass),
      .timeout           (timeout),
      .error_count       (error_count),
      .first_err_address (first_err_address),
      .first_err_read    (first_err_read),
      .first_err_expected(first_err_expected)
   );

   // 0 ideal, 1 addr 5 reads DEAD in pass 0, 2 bit0 stuck at 0, 3 no write ack
   int          mode = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] mem [16];
   int          cnt = 0;
   logic        responded = 1'b0;
   logic [1:0]  cmd_prev = 2'd0;
   int          wr_n = 0, rd_n = 0, req_n = 0, gap_bad = 0;
   logic [15:0] rd_w;

   always @(posedge clk) begin
      data_write_done <= 1'b0;
      data_read_valid <= 1'b0;
      cmd_prev <= command;
      if (cmd_prev == CMD_IDLE && command != CMD_IDLE)
         req_n <= req_n + 1;
      if (cmd_prev != CMD_IDLE && command != CMD_IDLE && cmd_prev != command)
         gap_bad <= gap_bad + 1;
      if (command == CMD_IDLE) begin
         cnt <= 0;
         responded <= 1'b0;
      end else if (!responded && mode != 3) begin
         if (cnt == 2) begin
            responded <= 1'b1;
            if (command == CMD_WRITE) begin
               mem[data_address[3:0]] <= data_write;
               data_write_done <= 1'b1;
               wr_n <= wr_n + 1;
            end else begin
               rd_w = mem[data_address[3:0]];
               if (mode == 1 && data_address[3:0] == 4'd5 && rd_w == 16'h0005)
                  rd_w = 16'hDEAD;
               if (mode == 2)
                  rd_w = rd_w & 16'hFFFE;
               data_read <= rd_w;
               data_read_valid <= 1'b1;
               rd_n <= rd_n + 1;
            end
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   int n, w0, r0, q0, k;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd", command, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", error_count, 0);
      check("rst_addr", data_address, 0);
      check("rst_fea", first_err_address, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // ideal memory, full two-pass run
      mode = 0;
      w0 = wr_n; r0 = rd_n; q0 = req_n;
      start_pulse();
      check("start_cmd", command, 1);
      check("start_busy", busy, 1);
      check("start_addr", data_address, 0);
      wait_done(n);
      check("ideal_cycles", n, 319);
      check("ideal_done", done, 1);
      check("ideal_pass", pass, 1);
      check("ideal_err", error_count, 0);
      check("ideal_busy", busy, 0);
      check("ideal_cmd", command, 0);
      check("ideal_writes", wr_n - w0, 32);
      check("ideal_reads", rd_n - r0, 32);
      check("ideal_reqs", req_n - q0, 64);
      check("gap_bad", gap_bad, 0);

      // forced DEAD at addr 5, with a start pulse while busy
      mode = 1;
      start_pulse();
      fork
         begin
            repeat (50) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join_none
      wait_done(n);
      check("dead_cycles", n, 319);
      check("dead_err", error_count, 1);
      check("dead_fea", first_err_address, 5);
      check("dead_fer", first_err_read, 16'hDEAD);
      check("dead_fee", first_err_expected, 16'h0005);
      check("dead_pass", pass, 0);
      check("dead_done", done, 1);

      // rerun from DONE: status cleared, identical result
      start_pulse();
      check("rerun_done", done, 0);
      check("rerun_err", error_count, 0);
      check("rerun_fea", first_err_address, 0);
      check("rerun_fer", first_err_read, 0);
      wait_done(n);
      check("rerun_cycles", n, 319);
      check("rerun_err2", error_count, 1);
      check("rerun_fea2", first_err_address, 5);
      check("rerun_pass", pass, 0);

      // bit 0 stuck at 0
      mode = 2;
      start_pulse();
      wait_done(n);
      check("stuck_err", error_count, 16);
      check("stuck_fea", first_err_address, 1);
      check("stuck_fee", first_err_expected, 16'h0001);
      check("stuck_fer", first_err_read, 16'h0000);
      check("stuck_pass", pass, 0);

      // controller never acknowledges writes
      mode = 3;
      start_pulse();
      wait_done(n);
      check("to_cycles", n, 1024);
      check("to_timeout", timeout, 1);
      check("to_done", done, 1);
      check("to_pass", pass, 0);
      check("to_cmd", command, 0);
      check("to_busy", busy, 0);

      // reset during pass-0 reads, then clean run
      mode = 0;
      start_pulse();
      k = 0;
      while (command != CMD_READ && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("reach_read", command, CMD_READ);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cmd", command, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_addr", data_address, 0);
      check("mid_rst_wdata", data_write, 0);
      check("mid_rst_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      start_pulse();
      wait_done(n);
      check("post_rst_cycles", n, 319);
      check("post_rst_pass", pass, 1);
      check("post_rst_err", error_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
